// File: rtl/fpu_classify.sv
// fpu_classify: IEEE-754 operand classifier (RISC-V fclass encoding) behind a
// 2-entry result FIFO with valid/ready handshakes on both sides. The class is
// decoded before the write, so each FIFO entry holds only the 10 class bits.
module fpu_classify #(
   parameter int Std = 31,
   parameter int Exp = 7,
   parameter int Man = 22
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [Std:0]   IEEE_A,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [Std:0]   class_out
);

   // Field bounds of the exponent inside the operand.
   localparam int ExpHi = Std - 1;
   localparam int ExpLo = Std - Exp - 1;

   // Pure field-compare decode to a one-hot fclass vector; no arithmetic, so
   // it works for any exponent/mantissa split.
   function automatic logic [9:0] classify(input logic [Std:0] a);
      logic         sign;
      logic [Exp:0] e;
      logic [Man:0] m;
      logic         e_ones;
      logic         e_zero;
      logic         m_zero;
      logic [9:0]   cls;
      sign   = a[Std];
      e      = a[ExpHi:ExpLo];
      m      = a[Man:0];
      e_ones = &e;
      e_zero = ~|e;
      m_zero = ~|m;
      cls    = 10'd0;
      if (e_ones) begin
         if (m_zero) begin
            if (sign) cls = 10'b00_0000_0001;
            else      cls = 10'b00_1000_0000;
         end else if (m[Man]) begin
            cls = 10'b10_0000_0000;
         end else begin
            cls = 10'b01_0000_0000;
         end
      end else if (e_zero) begin
         if (m_zero) begin
            if (sign) cls = 10'b00_0000_1000;
            else      cls = 10'b00_0001_0000;
         end else begin
            if (sign) cls = 10'b00_0000_0100;
            else      cls = 10'b00_0010_0000;
         end
      end else begin
         if (sign) cls = 10'b00_0000_0010;
         else      cls = 10'b00_0100_0000;
      end
      return cls;
   endfunction

   logic [9:0] mem_r [0:1];
   logic       wr_ptr_r;
   logic       rd_ptr_r;
   logic [1:0] count_r;
   logic       accept_s;
   logic       pop_s;
   logic [9:0] class_s;

   // Handshake qualifiers and the decoded class of the offered operand.
   always_comb begin
      accept_s = in_valid & in_ready;
      pop_s    = out_valid & out_ready;
      class_s  = classify(IEEE_A);
   end

   // Output decode from registered state only: ready from count, data masked when empty.
   always_comb begin
      in_ready  = (count_r != 2'd2);
      out_valid = (count_r != 2'd0);
      class_out = '0;
      if (count_r != 2'd0) begin
         class_out[9:0] = mem_r[rd_ptr_r];
      end else begin
         class_out[9:0] = 10'd0;
      end
   end

   // FIFO storage: written on accept; contents never need reset since empty masks them.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         mem_r[wr_ptr_r] <= class_s;
      end
   end

   // Pointer and occupancy control; reset wins over a same-cycle accept or pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (accept_s) wr_ptr_r <= ~wr_ptr_r;
         if (pop_s)    rd_ptr_r <= ~rd_ptr_r;
         case ({accept_s, pop_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_classify.sv
// Self-checking bench for fpu_classify: directed vector table, handshake
// corner sequences, a bfloat16 build, and randomized traffic against a queue model.
module tb_fpu_classify;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [31:0] ieee_a;
   logic [31:0] class_out;

   logic        bf_in_valid, bf_out_ready;
   logic        bf_in_ready, bf_out_valid;
   logic [15:0] bf_a;
   logic [15:0] bf_class_out;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fpu_classify dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .IEEE_A(ieee_a), .out_valid(out_valid), .out_ready(out_ready),
      .class_out(class_out)
   );

   fpu_classify #(.Std(15), .Exp(7), .Man(6)) dut_bf (
      .clk(clk), .rst(rst), .in_valid(bf_in_valid), .in_ready(bf_in_ready),
      .IEEE_A(bf_a), .out_valid(bf_out_valid), .out_ready(bf_out_ready),
      .class_out(bf_class_out)
   );

   typedef struct {
      logic [31:0] a;
      logic [9:0]  cls;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference class from IEEE rules: category by value, then mapped to its fclass slot.
   function automatic logic [9:0] ref_class(input logic [31:0] a, input int ew, input int mw);
      int unsigned sign, e, m, emax, quiet, cat, idx;
      logic [9:0] one;
      sign  = (a >> (ew + mw)) & 32'd1;
      e     = (a >> mw) & ((32'd1 << ew) - 32'd1);
      m     = a & ((32'd1 << mw) - 32'd1);
      emax  = (32'd1 << ew) - 32'd1;
      quiet = (m >> (mw - 1)) & 32'd1;
      // cat: 0 infinity, 1 normal, 2 subnormal, 3 zero (negative side order)
      if (e == emax && m == 0) cat = 0;
      else if (e != 0 && e != emax) cat = 1;
      else if (e == 0 && m != 0) cat = 2;
      else cat = 3;
      if (e == emax && m != 0) idx = quiet ? 9 : 8;
      else idx = sign ? cat : 7 - cat;
      one = 10'd1;
      return one << idx;
   endfunction

   function automatic logic [31:0] rand_operand();
      logic [7:0]  e;
      logic [22:0] m;
      case ($urandom_range(0, 3))
         0:       e = 8'h00;
         1:       e = 8'hFF;
         default: e = 8'($urandom);
      endcase
      case ($urandom_range(0, 3))
         0:       m = 23'd0;
         1:       m = 23'h400000 | 23'($urandom);
         2:       m = 23'($urandom) & 23'h3FFFFF;
         default: m = 23'($urandom);
      endcase
      return {1'($urandom), e, m};
   endfunction

   vec_t vecs [12];
   vec_t bvec [4];
   logic [9:0] q [$];
   logic [31:0] opnd;
   logic [31:0] head;
   bit acc, pp;

   initial begin
      vecs[0]  = '{32'hFF800000, 10'h001};
      vecs[1]  = '{32'h80000000, 10'h008};
      vecs[2]  = '{32'h00000001, 10'h020};
      vecs[3]  = '{32'h7FC00000, 10'h200};
      vecs[4]  = '{32'hFF800001, 10'h100};
      vecs[5]  = '{32'h3F800000, 10'h040};
      vecs[6]  = '{32'h7F800000, 10'h080};
      vecs[7]  = '{32'hBF800000, 10'h002};
      vecs[8]  = '{32'h807FFFFF, 10'h004};
      vecs[9]  = '{32'h00000000, 10'h010};
      vecs[10] = '{32'hFFFFFFFF, 10'h200};
      vecs[11] = '{32'h7F7FFFFF, 10'h040};
      bvec[0]  = '{32'h7F81, 10'h100};
      bvec[1]  = '{32'h8001, 10'h004};
      bvec[2]  = '{32'hFF80, 10'h001};
      bvec[3]  = '{32'h3F80, 10'h040};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ieee_a = 32'd0;
      bf_in_valid = 1'b0; bf_out_ready = 1'b0; bf_a = 16'd0;
      tick();
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_class_out", class_out, 32'd0);
      rst = 1'b0;

      // Streaming table: one operand per cycle, each visible one cycle after accept.
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1; out_ready = 1'b1; ieee_a = vecs[i].a;
         tick();
         check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("vec%0d_class", i), class_out, {22'd0, vecs[i].cls});
      end
      in_valid = 1'b0;
      tick();
      check("drain_valid", {31'd0, out_valid}, 32'd0);
      check("drain_class", class_out, 32'd0);

      // Backpressure: fill to two, then one pop reopens the input.
      out_ready = 1'b0; in_valid = 1'b1; ieee_a = 32'hBF800000;
      tick();
      ieee_a = 32'h00000000;
      tick();
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_class", class_out, 32'h002);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check("bp_pop_class", class_out, 32'h010);
      check("bp_pop_in_ready", {31'd0, in_ready}, 32'd1);

      // Full with pop: offered operand must wait a cycle, order preserved.
      out_ready = 1'b0; in_valid = 1'b1; ieee_a = 32'h3F800000;
      tick();
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      ieee_a = 32'h7F800000; out_ready = 1'b1;
      tick();
      check("fullpop_in_ready", {31'd0, in_ready}, 32'd1);
      check("fullpop_class", class_out, 32'h040);
      out_ready = 1'b0;
      tick();
      check("fullpop_late_accept", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check("fullpop_order", class_out, 32'h080);
      tick();
      check("fullpop_empty", {31'd0, out_valid}, 32'd0);

      // Reset while full, with accept and pop requested in the same cycle.
      out_ready = 1'b0; in_valid = 1'b1; ieee_a = 32'hFF800000;
      tick();
      ieee_a = 32'h80000000;
      tick();
      check("rstfull_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b1; out_ready = 1'b1; ieee_a = 32'h3F800000;
      tick();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_class", class_out, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rst_stale%0d", i), {31'd0, out_valid}, 32'd0);
      end

      // bfloat16 build.
      for (int i = 0; i < 4; i++) begin
         bf_in_valid = 1'b1; bf_out_ready = 1'b1; bf_a = bvec[i].a[15:0];
         tick();
         check($sformatf("bf%0d_valid", i), {31'd0, bf_out_valid}, 32'd1);
         check($sformatf("bf%0d_class", i), {16'd0, bf_class_out}, {22'd0, bvec[i].cls});
         check($sformatf("bf%0d_model", i), {22'd0, ref_class(bvec[i].a, 8, 7)}, {22'd0, bvec[i].cls});
      end
      bf_in_valid = 1'b0;
      tick();
      check("bf_drain", {31'd0, bf_out_valid}, 32'd0);

      // Randomized traffic against a queue model; occasional resets.
      q.delete();
      for (int c = 0; c < 400; c++) begin
         head = (q.size() > 0) ? {22'd0, q[0]} : 32'd0;
         check("rnd_in_ready", {31'd0, in_ready}, (q.size() < 2) ? 32'd1 : 32'd0);
         check("rnd_out_valid", {31'd0, out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
         check("rnd_class", class_out, head);
         opnd = rand_operand();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         rst       = ($urandom_range(0, 49) == 0);
         ieee_a    = opnd;
         acc = in_valid && (q.size() < 2);
         pp  = out_ready && (q.size() > 0);
         tick();
         if (rst) begin
            q.delete();
         end else begin
            if (pp)  void'(q.pop_front());
            if (acc) q.push_back(ref_class(opnd, 8, 23));
         end
      end
      rst = 1'b0; in_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
